crc32_fcs_checker: RTL and testbench
====================================

Name: crc32_fcs_checker

Overview:
Receive-side companion to the CRC32 parallel generator. It consumes a 32-bit word stream framed by sop/eop, with the 4-byte FCS at the tail, and runs the same CRC over data plus FCS at up to 4 bytes per cycle. At end of frame it reports one status pulse: CRC ok, length error or protocol error. It sits between the MAC receive datapath and the frame-accept logic.

Parameters:
LEN_W, 16, width of the byte-length counter and of frame_len
MIN_BYTES, 64, minimum legal frame length in bytes, FCS included
MAX_BYTES, 1522, maximum legal frame length in bytes, FCS included

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid; no backpressure, the block is always ready
s_sop  in  1  first beat of frame
s_eop  in  1  last beat of frame
s_bytes  in  2  valid bytes in eop beat (0=4, 1..3); ignored when s_eop=0
s_data  in  32  payload; [31:24] is the first byte on the wire
frame_done  out  1  one-cycle status strobe
crc_ok  out  1  residue matched and no protocol error; valid with frame_done
len_err  out  1  length below MIN_BYTES or above MAX_BYTES; valid with frame_done
proto_err  out  1  framing violation; valid with frame_done
frame_len  out  LEN_W  byte count of the frame, FCS included; valid with frame_done
crc_residue  out  32  final LFSR value, for debug; valid with frame_done

Behaviour:
- Interface: single clock clk. Reset reset_n is asynchronous and active-low. All outputs reset to 0, the FSM resets to IDLE and the LFSR resets to 32'hFFFFFFFF.
- CRC algorithm:
  - polynomial 32'h04C11DB7, init 32'hFFFFFFFF, MSB-first, no reflection, no final XOR; identical to the generator
  - the FCS is the generator's raw final register, sent MSB first
  - a good frame therefore leaves residue 32'h00000000
- Byte-granular update: a partial eop beat processes only the top s_bytes bytes, so the LFSR advances 8, 16, 24 or 32 bits.
- Pipeline:
  - stage 1 registers s_* unconditionally
  - stage 2 updates the LFSR, the length counter and the status registers
  - an eop beat sampled at edge k gives frame_done high for exactly the cycle after edge k+1
  - sustained back-to-back frames are supported at one beat per cycle
- FSM states:
  - IDLE: a beat with sop loads the LFSR from INIT and processes the beat, then goes to IN_FRAME; if eop is also set, the frame completes immediately and the FSM stays in IDLE.
  - IN_FRAME: beats update the LFSR; an eop beat completes the frame and returns to IDLE.
  - Cycles with s_valid=0 hold all state.
- Length counter:
  - adds 4 per beat, or the decoded s_bytes count on an eop beat
  - saturates at 2^LEN_W-1
  - len_err = (frame_len < MIN_BYTES) || (frame_len > MAX_BYTES)
- crc_ok = (residue == 0) && !proto_err. len_err does not affect crc_ok.
- Boundary cases:
  - sop while IN_FRAME: the old frame is closed with frame_done=1, proto_err=1, crc_ok=0 and its frame_len so far. The new frame starts from INIT on the same beat.
  - eop while IDLE without sop: the beat is dropped and frame_done=1, proto_err=1, crc_ok=0, frame_len=0.
  - non-sop beats in IDLE: dropped silently, no strobe.
  - single-beat frame (sop and eop together): legal framing; len_err is set if the frame is below MIN_BYTES.
  - reset mid-frame: the frame is discarded and no frame_done is issued.
- Status outputs hold their value until the next frame_done; only frame_done is a pulse.

Optional Feature:
CRC_CHK_STATS_EN:
- Defined:
  - adds input stats_clr (1 bit, synchronous clear)
  - adds outputs good_cnt and bad_cnt, each 32 bits, saturating, reset to 0
  - good_cnt increments on frame_done with crc_ok && !len_err
  - bad_cnt increments on every other frame_done
  - stats_clr takes priority over an increment in the same cycle
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package crc32_pkg holds:
  - POLYNOM, CRC_INIT and CRC_RESIDUE=32'h0
  - a byte-count decode helper for s_bytes
  - the fsm_state_t enum {IDLE, IN_FRAME}
- The generator is migrated to use this package as well.
- One combinational sub-module, crc32_byte_step: inputs crc_in[31:0], data[31:0] and nbytes[2:0] (1..4); output crc_out[31:0] after processing the top nbytes bytes. The checker instantiates it once.

Test Plan:
Bench parameters: MIN_BYTES=4 unless noted.
1. Good frame: "123456789" followed by FCS 03 76 E6 E7, sent as beats 0x31323334 (sop), 0x35363738, 0x390376E6, 0xE7000000 (eop, s_bytes=1). Expect frame_done 2 edges after the eop beat, crc_ok=1, crc_residue=0, frame_len=13, len_err=0.
2. Corrupted frame: same as 1 with the beat 0x35363738 changed to 0x35363739. Expect crc_ok=0, crc_residue≠0, proto_err=0.
3. Short frame with MIN_BYTES=64: a 13-byte good frame gives len_err=1 and crc_ok=1.
4. Framing errors:
   - sop at beat 3 of an open frame: expect proto_err=1 and frame_len=8 for the old frame; the new frame then checks good.
   - eop in IDLE: expect proto_err=1 and frame_len=0.
5. Stalls and back-to-back: insert s_valid=0 gaps mid-frame, then send two good frames with no idle cycle between them. Expect two frame_done strobes exactly 2 cycles apart, both crc_ok=1.
6. Reset and stats:
   - assert reset_n low mid-frame: expect no frame_done and all outputs 0 after reset.
   - with CRC_CHK_STATS_EN: send 3 good and 2 bad frames; expect good_cnt=3 and bad_cnt=2; stats_clr then zeroes both.

Source files
------------

// File: rtl/crc32_pkg.sv
// crc32_pkg: shared CRC-32 constants, FSM state type and helpers for the generator/checker pair.
// Revision 1.0
`default_nettype none

package crc32_pkg;

  localparam logic [31:0] POLYNOM     = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'h00000000;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } fsm_state_t;

  // s_bytes encodes a full 4-byte beat as 0
  function automatic logic [2:0] bytes_decode(input logic [1:0] b);
    return (b == 2'd0) ? 3'd4 : {1'b0, b};
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int k = 7; k >= 0; k--) begin
      fb = c[31] ^ d[k];
      c  = {c[30:0], 1'b0} ^ (fb ? POLYNOM : 32'h0);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_byte_step.sv
// crc32_byte_step: advances the CRC over the top nbytes (1..4) bytes of a 32-bit word, MSB first.
// Revision 1.0
`default_nettype none

module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) begin
        crc_out = crc_byte(crc_out, data[31-8*i -: 8]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crc32_fcs_checker.sv
// crc32_fcs_checker: receive-side FCS check with length/framing status; optional CRC_CHK_STATS_EN adds counters.
// Revision 1.0
`default_nettype none

module crc32_fcs_checker
  import crc32_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int MIN_BYTES = 64,
  parameter int MAX_BYTES = 1522
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic             s_sop,
  input  logic             s_eop,
  input  logic [1:0]       s_bytes,
  input  logic [31:0]      s_data,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             len_err,
  output logic             proto_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [31:0]      crc_residue
`ifdef CRC_CHK_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [31:0]      good_cnt,
  output logic [31:0]      bad_cnt
`endif
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] LEN_SAT = {LEN_W{1'b1}};

  // Stage 1: input capture
  logic        r_valid, r_sop, r_eop;
  logic [1:0]  r_bytes;
  logic [31:0] r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_bytes <= 2'd0;
      r_data  <= 32'h0;
    end else begin
      r_valid <= s_valid;
      r_sop   <= s_sop;
      r_eop   <= s_eop;
      r_bytes <= s_bytes;
      r_data  <= s_data;
    end
  end

  // Stage 2: LFSR, length and status
  fsm_state_t       r_state, w_state_nxt;
  logic [31:0]      r_lfsr, w_lfsr_nxt, w_crc_in, w_crc_step, w_resid;
  logic [LEN_W-1:0] r_len, w_len_nxt, w_len_acc, w_flen;
  logic [LEN_W:0]   w_len_sum;
  logic [2:0]       w_nbytes;
  logic             w_done, w_proto, w_crc_ok, w_len_err;

  assign w_nbytes  = r_eop ? bytes_decode(r_bytes) : 3'd4;
  assign w_crc_in  = r_sop ? CRC_INIT : r_lfsr;
  assign w_len_sum = {1'b0, r_len} + (LEN_W+1)'(w_nbytes);
  assign w_len_acc = w_len_sum[LEN_W] ? LEN_SAT : w_len_sum[LEN_W-1:0];

  crc32_byte_step u_step (
    .crc_in  (w_crc_in),
    .data    (r_data),
    .nbytes  (w_nbytes),
    .crc_out (w_crc_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // sop+eop arriving inside an open frame reports the old frame's error and drops the new single beat
  always_comb begin
    w_state_nxt = r_state;
    if (r_valid) begin
      case (r_state)
        IDLE:     if (r_sop && !r_eop) w_state_nxt = IN_FRAME;
        IN_FRAME: if (r_eop)           w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_done     = 1'b0;
    w_proto    = 1'b0;
    w_flen     = '0;
    w_resid    = r_lfsr;
    w_lfsr_nxt = r_lfsr;
    w_len_nxt  = r_len;
    if (r_valid) begin
      case (r_state)
        IDLE: begin
          if (r_sop) begin
            w_lfsr_nxt = w_crc_step;
            w_len_nxt  = LEN_W'(w_nbytes);
            if (r_eop) begin
              w_done  = 1'b1;
              w_flen  = LEN_W'(w_nbytes);
              w_resid = w_crc_step;
            end
          end else if (r_eop) begin
            w_done  = 1'b1;
            w_proto = 1'b1;
          end
        end
        IN_FRAME: begin
          w_lfsr_nxt = w_crc_step;
          if (r_sop) begin
            w_done    = 1'b1;
            w_proto   = 1'b1;
            w_flen    = r_len;
            w_len_nxt = LEN_W'(w_nbytes);
          end else begin
            w_len_nxt = w_len_acc;
            if (r_eop) begin
              w_done  = 1'b1;
              w_flen  = w_len_acc;
              w_resid = w_crc_step;
            end
          end
        end
        default: ;
      endcase
    end
    w_crc_ok  = (w_resid == CRC_RESIDUE) && !w_proto;
    w_len_err = (w_flen < MIN_LEN) || (w_flen > MAX_LEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr      <= CRC_INIT;
      r_len       <= '0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      len_err     <= 1'b0;
      proto_err   <= 1'b0;
      frame_len   <= '0;
      crc_residue <= 32'h0;
    end else begin
      r_lfsr     <= w_lfsr_nxt;
      r_len      <= w_len_nxt;
      frame_done <= w_done;
      if (w_done) begin
        crc_ok      <= w_crc_ok;
        len_err     <= w_len_err;
        proto_err   <= w_proto;
        frame_len   <= w_flen;
        crc_residue <= w_resid;
      end
    end
  end

`ifdef CRC_CHK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt <= 32'h0;
      bad_cnt  <= 32'h0;
    end else if (stats_clr) begin
      good_cnt <= 32'h0;
      bad_cnt  <= 32'h0;
    end else if (frame_done) begin
      if (crc_ok && !len_err) begin
        if (good_cnt != 32'hFFFFFFFF) good_cnt <= good_cnt + 32'd1;
      end else begin
        if (bad_cnt != 32'hFFFFFFFF) bad_cnt <= bad_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc32_fcs_checker.sv
// tb_crc32_fcs_checker: scoreboard bench; a MIN_BYTES=4 and a MIN_BYTES=64 instance share one stimulus stream.
`default_nettype none
`timescale 1ns/1ps

module tb_crc32_fcs_checker;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int len;
    bit ok;
    bit lenerr;
    bit lenerr64;
    bit proto;
    int rz;   // 0 don't care, 1 residue zero, 2 residue non-zero
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
  logic [1:0]  s_bytes = 2'd0;
  logic [31:0] s_data = 32'h0;
  logic        frame_done, crc_ok, len_err, proto_err;
  logic [15:0] frame_len;
  logic [31:0] crc_residue;
  logic        frame_done_b, crc_ok_b, len_err_b, proto_err_b;
  logic [15:0] frame_len_b;
  logic [31:0] crc_residue_b;
`ifdef CRC_CHK_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] good_cnt, bad_cnt, good_cnt_b, bad_cnt_b;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc32_fcs_checker #(.LEN_W(16), .MIN_BYTES(4), .MAX_BYTES(1522)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_bytes(s_bytes), .s_data(s_data), .frame_done(frame_done), .crc_ok(crc_ok),
    .len_err(len_err), .proto_err(proto_err), .frame_len(frame_len), .crc_residue(crc_residue)
`ifdef CRC_CHK_STATS_EN
    , .stats_clr(stats_clr), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  crc32_fcs_checker #(.LEN_W(16), .MIN_BYTES(64), .MAX_BYTES(1522)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_bytes(s_bytes), .s_data(s_data), .frame_done(frame_done_b), .crc_ok(crc_ok_b),
    .len_err(len_err_b), .proto_err(proto_err_b), .frame_len(frame_len_b), .crc_residue(crc_residue_b)
`ifdef CRC_CHK_STATS_EN
    , .stats_clr(stats_clr), .good_cnt(good_cnt_b), .bad_cnt(bad_cnt_b)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference CRC: shift-register form, MSB first, no reflection, no final XOR
  function automatic logic [31:0] ref_crc(input bq_t b);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {b[i], 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  function automatic bq_t make_good(input bq_t p);
    bq_t         q = p;
    logic [31:0] c = ref_crc(p);
    q.push_back(c[31:24]); q.push_back(c[23:16]); q.push_back(c[15:8]); q.push_back(c[7:0]);
    return q;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  function automatic exp_t mk(input int len, input bit ok, input bit proto, input int rz);
    exp_t e;
    e.len = len; e.ok = ok; e.proto = proto; e.rz = rz; e.cyc = 0;
    e.lenerr   = (len < 4)  || (len > 1522);
    e.lenerr64 = (len < 64) || (len > 1522);
    return e;
  endfunction

  task automatic push_exp(input exp_t e);
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic drive_beat(input bit sop, input bit eop, input logic [1:0] nb, input logic [31:0] d);
    s_valid = 1'b1; s_sop = sop; s_eop = eop; s_bytes = nb; s_data = d;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_bytes = 2'd0; s_data = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input bq_t b, input exp_t e, input int gap_after, input bit close);
    int n  = b.size();
    int nb = (n + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      logic [31:0] d;
      int          rem;
      bit          eop;
      d = 32'h0;
      rem = n - 4*i;
      for (int j = 0; j < 4; j++) if (4*i + j < n) d[31-8*j -: 8] = b[4*i+j];
      eop = close && (i == nb - 1);
      if (eop) push_exp(e);
      drive_beat(i == 0, eop, (rem >= 4) ? 2'd0 : 2'(rem), d);
      if (i == gap_after) idle(2);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("done_cycle", cyc, e.cyc);
        check_val("frame_len",  32'(frame_len), 32'(e.len));
        check_val("crc_ok",     32'(crc_ok),    32'(e.ok));
        check_val("len_err",    32'(len_err),   32'(e.lenerr));
        check_val("proto_err",  32'(proto_err), 32'(e.proto));
        if (e.rz == 1) check_val("residue_zero", crc_residue, 32'h0);
        if (e.rz == 2) check_val("residue_nonzero", 32'(crc_residue != 32'h0), 32'd1);
        check_val("b_done",     32'(frame_done_b), 32'd1);
        check_val("b_len_err",  32'(len_err_b),    32'(e.lenerr64));
        check_val("b_crc_ok",   32'(crc_ok_b),     32'(e.ok));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_done"},  32'(frame_done), 32'd0);
    check_val({tag, "_ok"},    32'(crc_ok),     32'd0);
    check_val({tag, "_lenerr"},32'(len_err),    32'd0);
    check_val({tag, "_proto"}, 32'(proto_err),  32'd0);
    check_val({tag, "_len"},   32'(frame_len),  32'd0);
    check_val({tag, "_resid"}, crc_residue,     32'd0);
  endtask

  initial begin
    bq_t f1, f2, ga, gb, part;
    int  w;
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h03, 8'h76, 8'hE6, 8'hE7};
    f2 = f1;
    f2[7] = 8'h39;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // Good 13-byte frame, then the same frame with one corrupted byte
    send_frame(f1, mk(13, 1'b1, 1'b0, 1), -1, 1'b1);
    idle(3);
    send_frame(f2, mk(13, 1'b0, 1'b0, 2), -1, 1'b1);
    idle(3);

    // sop on beat 3 of an open frame, new frame must still check good
    part = rand_payload(8);
    send_frame(part, mk(0, 1'b0, 1'b0, 0), -1, 1'b0);
    push_exp(mk(8, 1'b0, 1'b1, 0));
    send_frame(f1, mk(13, 1'b1, 1'b0, 1), -1, 1'b1);
    idle(3);

    // eop with no open frame, and a stray non-sop beat that must be ignored
    drive_beat(1'b0, 1'b0, 2'd0, 32'hDEADBEEF);
    push_exp(mk(0, 1'b0, 1'b1, 0));
    drive_beat(1'b0, 1'b1, 2'd2, 32'h12345678);
    idle(3);

    // Stalls mid-frame, then two back-to-back 8-byte frames
    send_frame(f1, mk(13, 1'b1, 1'b0, 1), 1, 1'b1);
    ga = make_good(rand_payload(4));
    gb = make_good(rand_payload(4));
    send_frame(ga, mk(8, 1'b1, 1'b0, 1), -1, 1'b1);
    send_frame(gb, mk(8, 1'b1, 1'b0, 1), -1, 1'b1);
    idle(3);

    // Longer good frame with a 3-byte tail
    ga = make_good(rand_payload(67));
    send_frame(ga, mk(71, 1'b1, 1'b0, 1), 5, 1'b1);
    idle(3);

`ifdef CRC_CHK_STATS_EN
    stats_clr = 1'b1; idle(1); stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ga = make_good(rand_payload(12));
      send_frame(ga, mk(16, 1'b1, 1'b0, 1), -1, 1'b1);
    end
    send_frame(f2, mk(13, 1'b0, 1'b0, 2), -1, 1'b1);
    push_exp(mk(0, 1'b0, 1'b1, 0));
    drive_beat(1'b0, 1'b1, 2'd0, 32'h0);
    idle(4);
    check_val("good_cnt", good_cnt, 32'd3);
    check_val("bad_cnt",  bad_cnt,  32'd2);
    stats_clr = 1'b1; idle(1); stats_clr = 1'b0;
    @(negedge clk);
    check_val("good_cnt_clr", good_cnt, 32'd0);
    check_val("bad_cnt_clr",  bad_cnt,  32'd0);
    @(posedge clk); #1;
`endif

    // Reset in the middle of a frame: no strobe, everything back to zero
    w = 0;
    while (sb.size() != 0 && w < 50) begin idle(1); w++; end
    part = f1[0:7];
    send_frame(part, mk(0, 1'b0, 1'b0, 0), -1, 1'b0);
    reset_n = 1'b0;
    idle(2);
    @(negedge clk);
    check_outputs_zero("midreset");
`ifdef CRC_CHK_STATS_EN
    check_val("midreset_good_cnt", good_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(4);
    send_frame(f1, mk(13, 1'b1, 1'b0, 1), -1, 1'b1);

    w = 0;
    while (sb.size() != 0 && w < 50) begin idle(1); w++; end
    check_val("drain", 32'(sb.size()), 32'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
